// File: rtl/mem_pkg.sv
// Shared types and constants for the line-fill controller: FSM states, beat/line geometry and
// the word-address helper.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_LAT,
    WB_XFER,
    RD_LAT,
    RD_XFER,
    DONE
  } state_e;

  localparam int unsigned LINE_BEATS = 2;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned CNT_W      = 8;

  // A 16-byte line: addr[31:4] selects the line, addr[8:4] is the cache index.
  localparam int unsigned LINE_LSB = 4;
  localparam int unsigned LINE_MSB = 31;
  localparam int unsigned LINE_W   = LINE_MSB - LINE_LSB + 1;
  localparam int unsigned IDX_LSB  = 4;
  localparam int unsigned IDX_MSB  = IDX_LSB + IDX_W - 1;

  // Full word address before folding into the backing-store depth.
  function automatic logic [LINE_W:0] word_addr(input logic [LINE_W-1:0] line,
                                                input logic              beat);
    return {line, beat};
  endfunction

endpackage

// File: rtl/mem_store.sv
// Backing store: MEM_WORDS x 64-bit, one synchronous write port and one registered read port.
// Contents are deliberately not reset.
module mem_store
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [BEAT_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [BEAT_W-1:0] o_rdata
);

  logic [BEAT_W-1:0] r_mem [MEM_WORDS];
  logic [BEAT_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_fill_ctrl.sv
// Cache line-fill controller: arbitrates I/D misses, writes back dirty D victims, then streams
// a two-beat line from the backing store to the requesting cache.
module mem_fill_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 10,
  parameter int unsigned MEM_WORDS   = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      imiss,
  input  logic [31:0]               iaddr,
  input  logic                      dmiss,
  input  logic [31:0]               daddr,
  input  logic                      dwb,
  input  logic [31:0]               wb_addr,
  input  logic [LINE_BEATS*BEAT_W-1:0] wb_data,
  output logic                      ifill,
  output logic                      dfill,
  output logic [IDX_W-1:0]          fill_idx,
  output logic                      fill_beat,
  output logic [BEAT_W-1:0]         stream,
  output logic                      idone,
  output logic                      ddone
);

  localparam int unsigned      AW  = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  state_e                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_src_d;
  logic                          r_dwb;
  logic [LINE_W-1:0]             r_line;
  logic [LINE_W-1:0]             r_wb_line;
  logic [LINE_BEATS*BEAT_W-1:0]  r_wb_data;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_beat;
  logic                          r_ifill;
  logic                          r_dfill;
  logic                          r_fill_beat;
  logic                          r_idone;
  logic                          r_ddone;

  logic [LINE_W:0]   w_wr_word;
  logic [LINE_W:0]   w_rd_word;
  logic              w_wr_en;
  logic              w_rd_beat;
  logic [BEAT_W-1:0] w_wr_data;
  logic [BEAT_W-1:0] w_rdata;
  logic              w_unused;

  // Writes are suppressed while reset is high so an interrupted writeback stops cleanly.
  assign w_wr_en   = (r_state == WB_XFER) && !reset;
  assign w_wr_word = word_addr(r_wb_line, r_beat);
  assign w_wr_data = r_beat ? r_wb_data[2*BEAT_W-1:BEAT_W] : r_wb_data[BEAT_W-1:0];

  // Read port runs one cycle ahead: beat0 is addressed during RD_LAT, beat1 during beat0.
  assign w_rd_beat = (r_state == RD_XFER) && !r_beat;
  assign w_rd_word = word_addr(r_line, w_rd_beat);

  assign w_unused = ^{iaddr[LINE_LSB-1:0], daddr[LINE_LSB-1:0], wb_addr[LINE_LSB-1:0],
                      w_wr_word[LINE_W:AW], w_rd_word[LINE_W:AW], r_dwb};

  mem_store #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_store (
    .clk    (clk),
    .i_we   (w_wr_en),
    .i_waddr(w_wr_word[AW-1:0]),
    .i_wdata(w_wr_data),
    .i_raddr(w_rd_word[AW-1:0]),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_src_d     <= 1'b0;
      r_dwb       <= 1'b0;
      r_line      <= '0;
      r_wb_line   <= '0;
      r_wb_data   <= '0;
      r_idx       <= '0;
      r_beat      <= 1'b0;
      r_ifill     <= 1'b0;
      r_dfill     <= 1'b0;
      r_fill_beat <= 1'b0;
      r_idone     <= 1'b0;
      r_ddone     <= 1'b0;
    end else begin
      r_idone <= 1'b0;
      r_ddone <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (dmiss) begin
            r_src_d   <= 1'b1;
            r_dwb     <= dwb;
            r_line    <= daddr[LINE_MSB:LINE_LSB];
            r_idx     <= daddr[IDX_MSB:IDX_LSB];
            r_wb_line <= wb_addr[LINE_MSB:LINE_LSB];
            r_wb_data <= wb_data;
            r_cnt     <= LAT;
            r_state   <= dwb ? WB_LAT : RD_LAT;
          end else if (imiss) begin
            r_src_d <= 1'b0;
            r_dwb   <= 1'b0;
            r_line  <= iaddr[LINE_MSB:LINE_LSB];
            r_idx   <= iaddr[IDX_MSB:IDX_LSB];
            r_cnt   <= LAT;
            r_state <= RD_LAT;
          end
        end
        WB_LAT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_beat  <= 1'b0;
            r_state <= WB_XFER;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        WB_XFER: begin
          if (r_beat) begin
            r_beat  <= 1'b0;
            r_cnt   <= LAT;
            r_state <= RD_LAT;
          end else begin
            r_beat <= 1'b1;
          end
        end
        RD_LAT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt       <= '0;
            r_beat      <= 1'b0;
            r_ifill     <= !r_src_d;
            r_dfill     <= r_src_d;
            r_fill_beat <= 1'b0;
            r_state     <= RD_XFER;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RD_XFER: begin
          if (r_beat) begin
            r_beat      <= 1'b0;
            r_ifill     <= 1'b0;
            r_dfill     <= 1'b0;
            r_fill_beat <= 1'b0;
            r_idone     <= !r_src_d;
            r_ddone     <= r_src_d;
            r_state     <= DONE;
          end else begin
            r_beat      <= 1'b1;
            r_fill_beat <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ifill     = r_ifill;
  assign dfill     = r_dfill;
  assign fill_idx  = r_idx;
  assign fill_beat = r_fill_beat;
  assign stream    = (r_ifill || r_dfill) ? w_rdata : '0;
  assign idone     = r_idone;
  assign ddone     = r_ddone;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Directed bench for mem_fill_ctrl at MEM_LATENCY = 10; memory is preloaded through dirty
// writebacks so every expected beat is known.
module tb_mem_fill_ctrl;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         imiss, dmiss, dwb;
  logic [31:0]  iaddr, daddr, wb_addr;
  logic [127:0] wb_data;
  logic         ifill, dfill, fill_beat, idone, ddone;
  logic [4:0]   fill_idx;
  logic [63:0]  stream;

  int n_cmp = 0;
  int n_err = 0;

  mem_fill_ctrl #(
    .MEM_LATENCY(LAT),
    .MEM_WORDS  (4096)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .imiss    (imiss),
    .iaddr    (iaddr),
    .dmiss    (dmiss),
    .daddr    (daddr),
    .dwb      (dwb),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ifill    (ifill),
    .dfill    (dfill),
    .fill_idx (fill_idx),
    .fill_beat(fill_beat),
    .stream   (stream),
    .idone    (idone),
    .ddone    (ddone)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one miss from an IDLE cycle and follows it to completion plus one IDLE cycle.
  task automatic run_miss(input string tag, input logic is_d, input logic [31:0] addr,
                          input logic dirty, input logic [31:0] wba, input logic [127:0] wbd,
                          input logic drop, input logic chk_data, input logic [63:0] e0,
                          input logic [63:0] e1, input logic [4:0] e_idx);
    int          beat_cyc, done_cyc, wrong, exp_beat;
    logic [63:0] s0, s1;
    logic        b0, b1;
    exp_beat = dirty ? (2 * LAT + 3) : (LAT + 1);
    beat_cyc = 0;
    done_cyc = 0;
    wrong    = 0;
    s0 = '0; s1 = '0; b0 = 1'b1; b1 = 1'b0;
    if (is_d) begin
      dmiss = 1'b1; daddr = addr; dwb = dirty; wb_addr = wba; wb_data = wbd;
    end else begin
      imiss = 1'b1; iaddr = addr;
    end
    tick();
    if (drop) begin
      imiss = 1'b0; dmiss = 1'b0; dwb = 1'b0;
    end
    for (int cyc = 1; cyc <= 80 && done_cyc == 0; cyc++) begin
      if (ifill || dfill) begin
        if ((is_d && ifill) || (!is_d && dfill)) wrong++;
        if (beat_cyc == 0) begin
          beat_cyc = cyc; s0 = stream; b0 = fill_beat;
        end else begin
          s1 = stream; b1 = fill_beat;
        end
      end
      if (idone || ddone) begin
        done_cyc = cyc;
        if ((is_d && idone) || (!is_d && ddone)) wrong++;
        imiss = 1'b0; dmiss = 1'b0; dwb = 1'b0;
      end
      tick();
    end
    check_eq($sformatf("%s beat0_cycle", tag), 64'(beat_cyc), 64'(exp_beat));
    check_eq($sformatf("%s done_cycle", tag), 64'(done_cyc), 64'(exp_beat + 2));
    check_eq($sformatf("%s beat_numbers", tag), {62'd0, b1, b0}, 64'h2);
    check_eq($sformatf("%s wrong_source", tag), 64'(wrong), 64'd0);
    check_eq($sformatf("%s fill_idx", tag), 64'(fill_idx), 64'(e_idx));
    if (chk_data) begin
      check_eq($sformatf("%s stream0", tag), s0, e0);
      check_eq($sformatf("%s stream1", tag), s1, e1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_d, f_i, f_dd, f_id, both;
    logic [63:0] sd, si;
    reset = 1'b1;
    imiss = 1'b0; dmiss = 1'b0; dwb = 1'b0;
    iaddr = '0; daddr = '0; wb_addr = '0; wb_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst ifill", 64'(ifill), 64'd0);
    check_eq("rst dfill", 64'(dfill), 64'd0);
    check_eq("rst dones", {62'd0, idone, ddone}, 64'd0);
    check_eq("rst stream", stream, 64'd0);
    check_eq("rst fill_idx", 64'(fill_idx), 64'd0);

    // mem[32..33] <= 1,2 ; then mem[8..9] <= A,B while reading back line 0x100.
    run_miss("dirty_wb", 1'b1, 32'h200, 1'b1, 32'h100, {64'h2, 64'h1}, 1'b0, 1'b0,
             64'h0, 64'h0, 5'd0);
    run_miss("dirty_rd", 1'b1, 32'h100, 1'b1, 32'h40, {64'hB, 64'hA}, 1'b0, 1'b1,
             64'h1, 64'h2, 5'd16);
    run_miss("clean_i", 1'b0, 32'h40, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1, 64'hA, 64'hB, 5'd4);
    run_miss("drop_i", 1'b0, 32'h40, 1'b0, 32'h0, 128'h0, 1'b1, 1'b1, 64'hA, 64'hB, 5'd4);
    // Top line wraps onto words 4094/4095.
    run_miss("wrap_wb", 1'b1, 32'h40, 1'b1, 32'hFFFF_FFF0, {64'h55, 64'h44}, 1'b0, 1'b1,
             64'hA, 64'hB, 5'd4);
    run_miss("wrap_i", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1,
             64'h44, 64'h55, 5'd31);
    run_miss("alias_i", 1'b0, 32'h0000_FFF0, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1,
             64'h44, 64'h55, 5'd31);

    // Simultaneous I and D: D first, I accepted in the IDLE cycle after ddone.
    f_d = 0; f_i = 0; f_dd = 0; f_id = 0; both = 0; sd = '0; si = '0;
    imiss = 1'b1; iaddr = 32'h40;
    dmiss = 1'b1; daddr = 32'h100; dwb = 1'b0;
    tick();
    for (int cyc = 1; cyc <= 60 && f_id == 0; cyc++) begin
      if (ifill && dfill) both++;
      if (dfill && f_d == 0) begin f_d = cyc; sd = stream; end
      if (ifill && f_i == 0) begin f_i = cyc; si = stream; end
      if (ddone && f_dd == 0) begin f_dd = cyc; dmiss = 1'b0; end
      if (idone && f_id == 0) begin f_id = cyc; imiss = 1'b0; end
      tick();
    end
    check_eq("both dfill_cycle", 64'(f_d), 64'd11);
    check_eq("both ddone_cycle", 64'(f_dd), 64'd13);
    check_eq("both ifill_cycle", 64'(f_i), 64'd25);
    check_eq("both idone_cycle", 64'(f_id), 64'd27);
    check_eq("both overlap", 64'(both), 64'd0);
    check_eq("both d_stream0", sd, 64'h1);
    check_eq("both i_stream0", si, 64'hA);

    // Reset during the fifth RD_LAT cycle, imiss held throughout.
    imiss = 1'b1; iaddr = 32'h40;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst ifill", 64'(ifill), 64'd0);
    check_eq("midrst dones", {62'd0, idone, ddone}, 64'd0);
    check_eq("midrst stream", stream, 64'd0);
    check_eq("midrst fill_idx", 64'(fill_idx), 64'd0);
    run_miss("midrst_restart", 1'b0, 32'h40, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1,
             64'hA, 64'hB, 5'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 10: main-memory access latency in cycles, legal range 1..255.
REQ-002 Parameter MEM_WORDS, default 4096: backing-store depth in 64-bit words, power of two.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imiss  input  1  I-cache miss request; held high until idone.
REQ-006 iaddr  input  32  I-miss byte address.
REQ-007 dmiss  input  1  D-cache miss request; held high until ddone.
REQ-008 daddr  input  32  D-miss byte address.
REQ-009 dwb  input  1  D-cache victim is dirty; qualified by dmiss.
REQ-010 wb_addr  input  32  victim line byte address.
REQ-011 wb_data  input  128  victim line; beat0 = [63:0], beat1 = [127:64].
REQ-012 ifill  output  1  high while a beat is streamed to the I-cache.
REQ-013 dfill  output  1  high while a beat is streamed to the D-cache.
REQ-014 fill_idx  output  5  target line index, equal to addr[8:4] of the miss.
REQ-015 fill_beat  output  1  beat number within the line (0, then 1).
REQ-016 stream  output  64  fill data beat.
REQ-017 idone / ddone  output  1 each  one-cycle completion pulse per source.

Function
REQ-018 A line SHALL be 16 bytes (2 beats of 64 bits); word address = {addr[31:4], beat} mod MEM_WORDS.
REQ-019 FSM states SHALL be IDLE, WB_LAT, WB_XFER, RD_LAT, RD_XFER, DONE.
REQ-020 In IDLE, dmiss SHALL take priority over imiss; the winner's source, addresses, dwb and wb_data SHALL be latched on the accepting edge.
REQ-021 IDLE->WB_LAT if dmiss&dwb; IDLE->RD_LAT for clean dmiss or imiss-only; otherwise stay in IDLE.
REQ-022 WB_LAT and RD_LAT SHALL each last exactly MEM_LATENCY cycles, timed by an 8-bit down-counter.
REQ-023 WB_XFER SHALL last 2 cycles, writing beat0 then beat1 of the latched wb_data to the latched wb_addr; the FSM then enters RD_LAT.
REQ-024 RD_XFER SHALL last 2 cycles; fill_beat = 0 then 1; stream = memory word; ifill or dfill high per the latched source, never both.
REQ-025 DONE SHALL last 1 cycle, pulse idone or ddone per the latched source, then return to IDLE; requests are not sampled during DONE.
REQ-026 Latency: with acceptance at edge 0, a clean miss drives beat0 in cycle L+1, beat1 in L+2 and done in L+3; a dirty miss adds L+2 cycles.
REQ-027 Request deassertion after acceptance SHALL be ignored; the transaction always completes.
REQ-028 A simultaneous imiss and dmiss SHALL serve D first; I is served on the first IDLE cycle after ddone.
REQ-029 Outside RD_XFER, ifill = dfill = 0 and stream = 0; fill_idx holds the latched index.
REQ-030 Address bits above the MEM_WORDS range SHALL wrap silently.

Reset
REQ-031 On reset: state = IDLE, counter = 0, latched registers = 0, and all outputs = 0 on the next edge, including reset asserted mid-transaction.
REQ-032 Reset SHALL NOT clear backing-store contents; a write in progress is abandoned (a beat already written stays written).

Structure
REQ-033 Package mem_pkg SHALL hold the state enum, LINE_BEATS = 2, BEAT_W = 64, IDX_W = 5 and the line/index bit-slice constants.
REQ-034 Backing storage SHALL be a sub-module mem_store (1 read port, 1 write port, synchronous, MEM_WORDS x 64); the FSM and counter live in mem_fill_ctrl.

Verification (MEM_LATENCY = 10)
REQ-035 Clean imiss, iaddr = 0x0000_0040, mem[8] = 0xA, mem[9] = 0xB -> ifill in cycles 11 and 12, fill_idx = 4, stream = 0xA then 0xB, idone in cycle 13.
REQ-036 Dirty dmiss, wb_addr = 0x100, wb_data = {0x2, 0x1}, daddr = 0x200 -> mem[32] = 0x1 and mem[33] = 0x2 after cycle 12, dfill in cycles 23–24, ddone in cycle 25.
REQ-037 imiss and dmiss both asserted in the same cycle -> full D transaction with ddone first; I is accepted in the cycle after ddone and idone follows 13 cycles later.
REQ-038 reset pulsed in cycle 5 of RD_LAT -> next cycle all outputs = 0 and state = IDLE; a held imiss restarts with the full 10-cycle latency.
REQ-039 imiss dropped after acceptance -> fill and idone still occur at cycles 11–13.
REQ-040 iaddr = 0xFFFF_FFF8 with MEM_WORDS = 4096 -> reads wrap to mem[4094] and mem[4095], fill_idx = 31.
